// File: rtl/mem_dma_engine.sv
// Word-granular DMA engine sharing the CPU's unified memory port: block copy
// or constant fill, one word per grant, with alignment and zero-length checks.
module mem_dma_engine #(
    parameter int unsigned LEN_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [31:0]          fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 dma_req,
    input  logic                 dma_gnt,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [31:0]          data_q, data_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic                 mode_q, mode_d;
    logic                 err_q, err_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        count_d = count_q;
        mode_d  = mode_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    count_d = len;
                    mode_d  = mode;
                    // Fill mode writes straight from the data register.
                    data_d  = fill_data;
                    err_d   = 1'b0;
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (dst_addr[1:0] != 2'b00 ||
                                 (!mode && src_addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = mode ? WR : RD;
                    end
                end
            end
            RD: begin
                if (dma_gnt) begin
                    data_d  = mem_rdata;
                    state_d = WR;
                end
            end
            WR: begin
                if (dma_gnt) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    count_d = count_q - LEN_WIDTH'(1);
                    if (count_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = mode_q ? WR : RD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q == RD) || (state_q == WR);
    assign dma_req = busy;
    assign done    = (state_q == DONE);
    assign err     = (state_q == DONE) && err_q;

    // Grant gates the strobes in the same cycle; idle port drives zeros.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == RD && dma_gnt) begin
            mem_read = 1'b1;
            mem_addr = src_q;
        end else if (state_q == WR && dma_gnt) begin
            mem_write = 1'b1;
            mem_addr  = dst_q;
            mem_wdata = data_q;
        end
    end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Self-checking bench for mem_dma_engine: directed table, reset-abort sequence
// and randomized commands against a word-array reference model.
module tb_mem_dma_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] src_addr, dst_addr, fill_data;
    logic [8:0]  len;
    logic        busy, done, err, dma_req, dma_gnt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    mem_dma_engine #(.LEN_WIDTH(9)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .busy(busy), .done(done), .err(err),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    bit          gpat    [4096];

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0, wr_cnt = 0, viol = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (done) done_cnt++;
        if (mem_read && mem_write) viol++;
        if (!mem_read && !mem_write && (mem_addr != 0 || mem_wdata != 0)) viol++;
        if (!dma_gnt && (mem_read || mem_write)) viol++;
        if (dma_req !== busy) viol++;
        if (err && !done) viol++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_pat(input int at, input int n);
        for (int i = 0; i < 4096; i++) gpat[i] = !(i >= at && i < at + n);
    endtask

    function automatic bit is_bad(input bit m, input logic [31:0] s, input logic [31:0] d);
        return (d[1:0] != 2'b00) || (!m && s[1:0] != 2'b00);
    endfunction

    // Forward word-at-a-time semantics, so overlapping copies propagate.
    task automatic model_apply(input bit m, input logic [31:0] s, input logic [31:0] d,
                               input int l, input logic [31:0] f);
        if (l == 0 || is_bad(m, s, d)) return;
        for (int i = 0; i < l; i++) begin
            int di, si;
            di = int'(((d >> 2) + i) & 32'h3FF);
            si = int'(((s >> 2) + i) & 32'h3FF);
            ref_mem[di] = m ? f : ref_mem[si];
        end
    endtask

    // Cycles from accepting edge to the done cycle, given the grant pattern.
    function automatic int model_done(input bit m, input logic [31:0] s, input logic [31:0] d, input int l);
        int acc, c;
        if (l == 0 || is_bad(m, s, d)) return 1;
        acc = m ? l : 2 * l;
        c = 0;
        while (acc > 0 && c < 4096) begin
            if (gpat[c]) acc--;
            c++;
        end
        return c + 1;
    endfunction

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic run_cmd(input bit m, input logic [31:0] s, input logic [31:0] d, input int l,
                           input logic [31:0] f, input bit extra, input int exp_c,
                           output int done_off, output int busy_cnt, output bit err_seen);
        @(posedge clk); #1;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l[8:0]; fill_data = f;
        dma_gnt = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        done_off = -1; busy_cnt = 0; err_seen = 1'b0;
        for (int k = 0; k < 4000 && done_off < 0; k++) begin
            dma_gnt = gpat[k];
            if (extra && (k == 2 || k == exp_c - 1)) begin
                start = 1'b1; mode = ~m; src_addr = 32'h40; dst_addr = 32'h80;
                len = 9'd5; fill_data = 32'h55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_off = k + 1; err_seen = err; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        dma_gnt = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          m;
        logic [31:0] s, d;
        int          l;
        logic [31:0] f;
        int          st_at, st_len;
        bit          extra;
        logic [31:0] init100;
        bit          exp_err;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic do_run(input string nm, input bit m, input logic [31:0] s, input logic [31:0] d,
                          input int l, input logic [31:0] f, input bit extra, input int exp_done,
                          input bit exp_err);
        int  doff, bcnt;
        bit  e;
        bit  ok;
        ok = (l != 0) && !is_bad(m, s, d);
        viol = 0;
        run_cmd(m, s, d, l, f, extra, exp_done, doff, bcnt, e);
        model_apply(m, s, d, l, f);
        check({nm, "_done_cycle"}, 64'(doff), 64'(exp_done));
        check({nm, "_err"}, 64'(e), 64'(exp_err));
        check({nm, "_busy_cycles"}, 64'(bcnt), 64'(exp_done - 1));
        check({nm, "_reads"}, 64'(rd_cnt), 64'((ok && !m) ? l : 0));
        check({nm, "_writes"}, 64'(wr_cnt), 64'(ok ? l : 0));
        check({nm, "_port_rules"}, 64'(viol), 64'd0);
        check({nm, "_mem"}, 64'(mem_diffs()), 64'd0);
        if (extra) begin
            @(negedge clk);
            check({nm, "_start_ignored"}, {62'd0, busy, done}, 64'd0);
        end
    endtask

    initial begin
        vecs[0] = '{"copy",    1'b0, 32'h100, 32'h200, 4, 32'h0,        -1, 0, 1'b0, 32'h0, 1'b0, 9};
        vecs[1] = '{"fill",    1'b1, 32'h0,   32'h300, 3, 32'hDEADBEEF, -1, 0, 1'b0, 32'h0, 1'b0, 4};
        vecs[2] = '{"stall",   1'b0, 32'h100, 32'h500, 2, 32'h0,         1, 3, 1'b0, 32'h0, 1'b0, 8};
        vecs[3] = '{"len0",    1'b0, 32'h100, 32'h600, 0, 32'h0,        -1, 0, 1'b0, 32'h0, 1'b0, 1};
        vecs[4] = '{"baddst",  1'b0, 32'h100, 32'h202, 3, 32'h0,        -1, 0, 1'b0, 32'h0, 1'b1, 1};
        vecs[5] = '{"overlap", 1'b0, 32'h100, 32'h104, 3, 32'h0,        -1, 0, 1'b1, 32'hA, 1'b0, 7};

        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[64 + i] = 32'(i + 1);
            ref_mem[64 + i] = 32'(i + 1);
        end

        reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; dma_gnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy, done, err, dma_req, mem_read, mem_write}, 64'd0);
        check("reset_addr", {mem_addr, mem_wdata}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].init100 != 0) begin
                mem[64] = vecs[i].init100;
                ref_mem[64] = vecs[i].init100;
            end
            set_pat(vecs[i].st_at, vecs[i].st_len);
            do_run(vecs[i].name, vecs[i].m, vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].f,
                   vecs[i].extra, vecs[i].exp_done, vecs[i].exp_err);
        end
        check("copy_word3", mem[32'h20C >> 2], 32'd4);
        check("overlap_last", mem[32'h10C >> 2], 32'hA);

        // Abort a 6-word copy during the write of the 4th word.
        begin
            int dc;
            set_pat(-1, 0);
            for (int i = 0; i < 6; i++) begin
                mem[64 + i] = 32'(11 + i); ref_mem[64 + i] = 32'(11 + i);
                mem[256 + i] = 32'h0;      ref_mem[256 + i] = 32'h0;
            end
            @(posedge clk); #1;
            start = 1'b1; mode = 1'b0; src_addr = 32'h100; dst_addr = 32'h400; len = 9'd6;
            dma_gnt = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (7) @(posedge clk);
            #3;
            check("rst_pre_write", 64'(mem_write), 64'd1);
            dc = done_cnt;
            reset = 1'b1;
            #1;
            check("rst_async_outputs", {busy, done, err, dma_req, mem_read, mem_write}, 64'd0);
            check("rst_async_addr", {mem_addr, mem_wdata}, 64'd0);
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            dma_gnt = 1'b0;
            repeat (4) @(negedge clk);
            check("rst_no_done", 64'(done_cnt), 64'(dc));
            check("rst_idle", {62'd0, busy, done}, 64'd0);
            model_apply(1'b0, 32'h100, 32'h400, 3, 32'h0);
            check("rst_mem", 64'(mem_diffs()), 64'd0);
        end
        do_run("after_rst", 1'b0, 32'h100, 32'h440, 6, 32'h0, 1'b0, 13, 1'b0);

        for (int r = 0; r < 25; r++) begin
            bit          m;
            logic [31:0] s, d, f;
            int          l;
            m = 1'($urandom);
            s = {20'd0, 10'($urandom), 2'b00};
            d = {20'd0, 10'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
            l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
            f = $urandom;
            for (int i = 0; i < 4096; i++) gpat[i] = ($urandom_range(0, 3) != 0);
            do_run("rand", m, s, d, l, f, 1'b0, model_done(m, s, d, l), is_bad(m, s, d) && l != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_dma_engine.md
# mem_dma_engine

Word-granular DMA engine that acts as a second initiator on the multi-cycle CPU's unified instruction/data memory port (combinational read, write on rising clk). It copies a block of words from one memory region to another, or fills a region with a constant, after the CPU grants it the memory port. It drives the same Address / Write_data / MemRead / MemWrite / Mem_data signal set that the CPU drives, so it plugs into the memory's input-side mux.

## Interface
- LEN_WIDTH, 9: width of word-count input; max transfer 2^LEN_WIDTH-1 words
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  32  copy source byte address, word aligned
- dst_addr  in  32  destination byte address, word aligned
- len  in  LEN_WIDTH  transfer length in words
- fill_data  in  32  fill pattern for mode 1
- busy  out  1  high while a transfer is in progress (states RD, WR)
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error flag, coincident with done
- dma_req  out  1  memory-port request, equal to busy
- dma_gnt  in  1  memory-port grant from the CPU-side arbiter
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- States: IDLE, RD, WR, DONE. Reset → IDLE. At reset, all outputs are 0 and the internal src, dst, count and data registers are 0.
- IDLE: on start=1, latch src_addr, dst_addr, len, fill_data and mode.
  - If len==0: go to DONE, err=0, no memory access.
  - Else if dst_addr[1:0]!=0, or (mode==0 and src_addr[1:0]!=0): go to DONE with err=1, no memory access.
  - Else: go to RD (copy) or WR (fill).
- RD (copy only): mem_addr=src, mem_read=dma_gnt. If dma_gnt=1, capture mem_rdata into the data register and go to WR. If dma_gnt=0, stay in RD.
- WR: mem_addr=dst, mem_wdata=data register (copy) or latched fill_data (fill), mem_write=dma_gnt.
  - If dma_gnt=0: stay in WR, holding data and address.
  - If dma_gnt=1: dst+=4, src+=4, count-=1. If the old count==1, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
- DONE: done=1 for exactly one cycle, err as latched, busy=0. Next state is IDLE.
- mem_read and mem_write are never both 1. When neither is asserted, mem_addr=0 and mem_wdata=0.
- Addresses increment modulo 2^32 with no clamping. The memory decodes only the low address bits, so wrap inside the memory is the memory's behaviour.
- Overlapping copies run forward, one word at a time. With dst>src the overlap propagates source words; this is defined behaviour, not an error.
- start is ignored outside IDLE, including the DONE cycle.
- Reset mid-transfer returns to IDLE immediately and drives outputs to 0. A write whose edge coincides with reset assertion is not committed. No done pulse is produced.

## Timing
- start accepted at edge T. busy=dma_req=1 from T+1. If len is 0 or an address is bad: done=1 during T+1 and busy stays 0.
- Copy, gnt held high: word k reads in cycle T+1+2k and writes in T+2+2k. N words take 2N busy cycles; done is high in T+2N+1.
- Fill, gnt held high: one write per cycle, N busy cycles; done is high in T+N+1.
- Each cycle with dma_gnt=0 in RD or WR adds exactly one cycle of latency, with no access issued.
- dma_gnt is sampled combinationally into mem_read/mem_write. The arbiter must switch the memory mux in the same cycle it asserts gnt.
- Only registered outputs: done, err, busy and dma_req come from the state register. The mem_* outputs are combinational from state, address/data registers and dma_gnt.

## Test plan
- Copy: memory words 0x100..0x10C = 1,2,3,4; start mode=0, src=0x100, dst=0x200, len=4, gnt=1. Require 0x200..0x20C = 1,2,3,4, 8 busy cycles, done in cycle 9 after start, err=0.
- Fill: mode=1, dst=0x300, len=3, fill_data=0xDEADBEEF, gnt=1. Require three consecutive writes to 0x300/0x304/0x308, then done, with mem_read never asserted.
- Grant stall: copy len=2 with gnt low for 3 cycles during the first WR. Require mem_write=0 during the stall, the same address and data held, correct result, and done 3 cycles later than the unstalled case.
- Errors: len=0 → done with err=0 one cycle after start. dst=0x202 → done with err=1. Neither case performs any mem_read or mem_write.
- Overlap and ignore: copy src=0x100, dst=0x104, len=3 with 0x100=0xA. Require 0x104..0x10C all 0xA. A second start pulse asserted while busy has no effect.
- Reset mid-copy (after 3 words of 6): outputs go to 0 asynchronously, state returns to IDLE, no done pulse. A fresh start afterwards completes normally.
